mmio_bridge: RTL and testbench
==============================

Name: mmio_bridge

Overview:
Parametrised successor to the single-cycle data-side memory/IO steering path: it decodes the data address into a memory path or one of N_CH IO channels. Memory accesses pass through combinationally. IO accesses become multi-cycle valid/ack transactions with a CPU stall, a per-access timeout and a sticky bus-error record. It sits between the execute/controller outputs, the data memory and the register-file write-back mux.

Parameters:
DATA_W, 32, data width
ADDR_W, 32, address width
N_CH, 4, number of IO channels (1..16)
IO_LOW, 10, addr_in[ADDR_W-1:IO_LOW] all ones selects the IO window (0xFFFFFC00 up)
CH_OFF_W, 4, byte-offset bits inside one channel (16 B per channel)
TIMEOUT_CYC, 15, maximum cycles in REQ waiting for ack before error
ERR_DATA, 32'hFFFF_FFFF, read data returned on error

Ports:
cpu_clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low
m_read  in  1  memory read (controller)
m_write  in  1  memory write
io_read  in  1  IO read
io_write  in  1  IO write
addr_in  in  ADDR_W  ALU result address
r_rdata  in  DATA_W  store data from register file
m_rdata  in  DATA_W  data memory read data
addr_out  out  ADDR_W  address to data memory
write_data  out  DATA_W  data memory write data
r_wdata  out  DATA_W  load data to write-back mux
cpu_stall  out  1  CPU holds PC and all state while high
ch_req  out  N_CH  one-hot IO request
ch_we  out  1  1 = write transaction
ch_addr  out  CH_OFF_W  offset inside channel
ch_wdata  out  DATA_W  IO write data
ch_rdata  in  N_CH*DATA_W  per-channel read data, channel i at [i*DATA_W +: DATA_W]
ch_ack  in  N_CH  per-channel acknowledge
err_clr  in  1  clears bus_err
bus_err  out  1  sticky error flag
err_addr  out  ADDR_W  address of most recent error

Behaviour:
- Reset (reset=0, async): state IDLE; ch_req=0, ch_we=0, ch_addr=0, ch_wdata=0, cpu_stall=0, bus_err=0, err_addr=0, wait counter=0, read latch=0.
- Memory path (combinational): addr_out=addr_in; write_data=r_rdata; r_wdata=m_rdata when m_read, and state IDLE with no IO access.
- io_access = (io_read|io_write) & IO window hit. ch = addr_in[CH_OFF_W +: clog2(N_CH)]. Index bits above that, up to IO_LOW-1, must be zero, else out-of-range.
- States IDLE, REQ, DONE, ERR.
- IDLE: if io_access, cpu_stall=1 (combinational). At the edge, latch addr, we=io_write, wdata=r_rdata and ch, then go to REQ. An out-of-range address goes to ERR instead. Without io_access, stay in IDLE with cpu_stall=0.
- REQ: ch_req[ch]=1 (registered, held), cpu_stall=1, counter increments each cycle. Acks on unselected channels are ignored.
  - If ch_ack[ch]=1, capture ch_rdata[ch] for reads and go to DONE.
  - Otherwise, when counter reaches TIMEOUT_CYC, go to ERR.
- DONE: one cycle; ch_req=0, cpu_stall=0, r_wdata=read latch. The CPU retires the instruction at this edge. Next state is IDLE unconditionally, so the same instruction cannot retrigger.
- ERR: one cycle; cpu_stall=0, r_wdata=ERR_DATA, bus_err<=1, err_addr<=latched addr. Next state is IDLE.
- Latency: ack in the first REQ cycle gives 2 stall cycles; the instruction completes in the 3rd cycle. Timeout gives 1+TIMEOUT_CYC stall cycles. Out-of-range gives 1 stall cycle.
- err_clr clears bus_err. If err_clr coincides with an ERR entry, set wins.
- Simultaneous m_* and io_* with an IO window hit: the IO path is taken and r_wdata is sourced from IO.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. The pending channel sees ch_req drop.
- Inputs change only while cpu_stall=0; the CPU guarantees this.

Decomposition:
- Shared package: state encoding (IDLE/REQ/DONE/ERR), IO window constants, ERR_DATA default.
- One sub-module: mmio_decode (combinational window hit, channel index, out-of-range).

Test Plan:
- m_read, addr 0x0000_0040, m_rdata=0x1234_5678 -> r_wdata=0x1234_5678, cpu_stall=0, ch_req=0.
- io_write, addr 0xFFFF_FC10 (ch1), r_rdata=0xA5; ch_ack[1] asserted in 1st REQ cycle -> ch_req=4'b0010, ch_we=1, ch_wdata=0xA5; 2 stall cycles, DONE on 3rd.
- io_read ch2, ack after 4 REQ cycles with data 0x55 -> 5 stall cycles; r_wdata=0x55 in DONE; ack on ch0 during wait ignored.
- io_read ch3, never acked -> stall for 1+15 cycles, r_wdata=0xFFFF_FFFF, bus_err=1, err_addr=0xFFFF_FC30; err_clr then drops bus_err.
- io_read addr 0xFFFF_FD00 (out of range) -> no ch_req, 1 stall cycle, ERR; err_clr in the same ERR cycle leaves bus_err=1.
- reset low during REQ -> ch_req=0 and cpu_stall=0 asynchronously; next io access proceeds normally.

Source files
------------

// File: rtl/mmio_bridge_pkg.sv
// Shared definitions for the MMIO bridge: transaction states, IO window
// defaults and the read data returned on a failed IO access.
package mmio_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam int unsigned IO_LOW_DEF   = 10;
  localparam int unsigned CH_OFF_W_DEF = 4;
  localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

  // Channel index width; a single channel still needs a 1-bit index signal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_decode.sv
// Combinational IO window decode: window hit, channel index and
// out-of-range detection for the channel-select field of the address.
module mmio_decode
  import mmio_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned IO_LOW   = IO_LOW_DEF,
  parameter int unsigned CH_OFF_W = CH_OFF_W_DEF,
  parameter int unsigned CH_W     = idx_w(N_CH)
) (
  input  logic [ADDR_W-CH_OFF_W-1:0] addr_hi,
  output logic                       win_hit,
  output logic [CH_W-1:0]            ch,
  output logic                       out_of_range
);

  localparam int unsigned SEL_W = IO_LOW - CH_OFF_W;

  logic [SEL_W-1:0] sel;

  assign win_hit = &addr_hi[ADDR_W-CH_OFF_W-1:SEL_W];
  assign sel     = addr_hi[SEL_W-1:0];
  assign ch      = sel[CH_W-1:0];

  // Any select value past the last channel (non-zero high bits included) is unmapped.
  assign out_of_range = (32'(sel) >= 32'(N_CH));

endmodule

// File: rtl/mmio_bridge.sv
// Data-side steering between data memory and N_CH IO channels. Memory
// accesses pass straight through; IO accesses run a stalled valid/ack handshake.
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        N_CH        = 4,
  parameter int unsigned        IO_LOW      = IO_LOW_DEF,
  parameter int unsigned        CH_OFF_W    = CH_OFF_W_DEF,
  parameter int unsigned        TIMEOUT_CYC = 15,
  parameter logic [DATA_W-1:0]  ERR_DATA    = DATA_W'(ERR_DATA_DEF)
) (
  input  logic                     cpu_clk,
  input  logic                     reset,
  input  logic                     m_read,
  input  logic                     m_write,
  input  logic                     io_read,
  input  logic                     io_write,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic [DATA_W-1:0]        r_rdata,
  input  logic [DATA_W-1:0]        m_rdata,
  output logic [ADDR_W-1:0]        addr_out,
  output logic [DATA_W-1:0]        write_data,
  output logic [DATA_W-1:0]        r_wdata,
  output logic                     cpu_stall,
  output logic [N_CH-1:0]          ch_req,
  output logic                     ch_we,
  output logic [CH_OFF_W-1:0]      ch_addr,
  output logic [DATA_W-1:0]        ch_wdata,
  input  logic [N_CH*DATA_W-1:0]   ch_rdata,
  input  logic [N_CH-1:0]          ch_ack,
  input  logic                     err_clr,
  output logic                     bus_err,
  output logic [ADDR_W-1:0]        err_addr
);

  localparam int unsigned CH_W  = idx_w(N_CH);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [N_CH-1:0]     ch_req_q, ch_req_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bus_err_q, bus_err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

  logic                win_hit, oor, io_access, ack_sel;
  logic [CH_W-1:0]     dec_ch;
  logic                unused_m_write;

  mmio_decode #(
    .ADDR_W   (ADDR_W),
    .N_CH     (N_CH),
    .IO_LOW   (IO_LOW),
    .CH_OFF_W (CH_OFF_W),
    .CH_W     (CH_W)
  ) u_decode (
    .addr_hi      (addr_in[ADDR_W-1:CH_OFF_W]),
    .win_hit      (win_hit),
    .ch           (dec_ch),
    .out_of_range (oor)
  );

  // Memory stores are decoded by the data memory itself; the bridge only forwards data.
  assign unused_m_write = m_write;

  assign io_access = (io_read | io_write) & win_hit;
  assign ack_sel   = ch_ack[ch_q];

  // NOTE: every flop, including the wide data latches, gets an async reset
  // and is written with <= so all registers update together at the edge.
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ch_q       <= '0;
      ch_req_q   <= '0;
      cnt_q      <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ch_q       <= ch_d;
      ch_req_q   <= ch_req_d;
      cnt_q      <= cnt_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (io_access) state_d = oor ? ST_ERR : ST_REQ;
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        // An ack in the final allowed cycle still wins over the timeout.
        if (ack_sel)                              state_d = ST_DONE;
        else if (cnt_d == CNT_W'(TIMEOUT_CYC))    state_d = ST_ERR;
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ch_d       = ch_q;
    ch_req_d   = ch_req_q;
    bus_err_d  = bus_err_q;
    err_addr_d = err_addr_q;

    if (state_q == ST_IDLE && io_access) begin
      addr_d  = addr_in;
      we_d    = io_write;
      wdata_d = r_rdata;
      ch_d    = dec_ch;
      if (!oor) begin
        ch_req_d         = '0;
        ch_req_d[dec_ch] = 1'b1;
      end
    end
    if (state_q == ST_REQ && state_d != ST_REQ) ch_req_d = '0;
    if (state_q == ST_REQ && ack_sel && !we_q)  rdata_d  = ch_rdata[ch_q*DATA_W +: DATA_W];

    // Error set is ordered after the clear so a coincident set wins.
    if (err_clr) bus_err_d = 1'b0;
    if (state_q == ST_ERR) begin
      bus_err_d  = 1'b1;
      err_addr_d = addr_q;
    end

    cpu_stall = reset && ((state_q == ST_IDLE && io_access) || state_q == ST_REQ);

    r_wdata = '0;
    unique case (state_q)
      ST_DONE: r_wdata = rdata_q;
      ST_ERR:  r_wdata = ERR_DATA;
      ST_IDLE: if (m_read && !io_access) r_wdata = m_rdata;
      default: r_wdata = '0;
    endcase
  end

  assign addr_out   = addr_in;
  assign write_data = r_rdata;
  assign ch_req     = ch_req_q;
  assign ch_we      = we_q;
  assign ch_addr    = addr_q[CH_OFF_W-1:0];
  assign ch_wdata   = wdata_q;
  assign bus_err    = bus_err_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed scenarios plus randomized IO
// traffic, each predicted from address arithmetic and ack timing.
module tb_mmio_bridge;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int N_CH    = 4;
  localparam int TIMEOUT = 15;
  localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;
  localparam logic [31:0] ERR_VAL = 32'hFFFF_FFFF;

  logic                   cpu_clk = 1'b0;
  logic                   reset;
  logic                   m_read, m_write, io_read, io_write, err_clr;
  logic [ADDR_W-1:0]      addr_in;
  logic [DATA_W-1:0]      r_rdata, m_rdata;
  logic [ADDR_W-1:0]      addr_out;
  logic [DATA_W-1:0]      write_data, r_wdata;
  logic                   cpu_stall;
  logic [N_CH-1:0]        ch_req;
  logic                   ch_we;
  logic [3:0]             ch_addr;
  logic [DATA_W-1:0]      ch_wdata;
  logic [N_CH*DATA_W-1:0] ch_rdata;
  logic [N_CH-1:0]        ch_ack;
  logic                   bus_err;
  logic [ADDR_W-1:0]      err_addr;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state of the bridge's architecturally visible records.
  logic              m_bus_err  = 1'b0;
  logic [31:0]       m_err_addr = '0;
  logic [31:0]       m_last_rd  = '0;

  mmio_bridge dut (
    .cpu_clk    (cpu_clk),
    .reset      (reset),
    .m_read     (m_read),
    .m_write    (m_write),
    .io_read    (io_read),
    .io_write   (io_write),
    .addr_in    (addr_in),
    .r_rdata    (r_rdata),
    .m_rdata    (m_rdata),
    .addr_out   (addr_out),
    .write_data (write_data),
    .r_wdata    (r_wdata),
    .cpu_stall  (cpu_stall),
    .ch_req     (ch_req),
    .ch_we      (ch_we),
    .ch_addr    (ch_addr),
    .ch_wdata   (ch_wdata),
    .ch_rdata   (ch_rdata),
    .ch_ack     (ch_ack),
    .err_clr    (err_clr),
    .bus_err    (bus_err),
    .err_addr   (err_addr)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic cmp(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic idle_inputs();
    m_read = 0; m_write = 0; io_read = 0; io_write = 0; err_clr = 0;
    ch_ack = '0;
  endtask

  // One IO access; delay = REQ cycle in which the selected channel acks
  // (anything above TIMEOUT means never).
  task automatic do_io(input string name, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int delay, input bit noise, input bit clr_in_err,
                       input bit also_mem);
    int idx, stalls, r, exp_stalls;
    bit oor, ok;
    logic [N_CH-1:0] exp_req;
    logic [31:0] exp_rd;

    idx        = int'((addr - IO_BASE) / 16);
    oor        = idx >= N_CH;
    ok         = !oor && delay <= TIMEOUT;
    exp_stalls = oor ? 1 : (ok ? 1 + delay : 1 + TIMEOUT);
    exp_req    = oor ? '0 : N_CH'(1) << idx;

    for (int i = 0; i < N_CH; i++) ch_rdata[i*DATA_W +: DATA_W] = $urandom;
    io_read  = !wr;
    io_write = wr;
    addr_in  = addr;
    r_rdata  = wdata;
    m_read   = also_mem;
    m_rdata  = 32'hDEAD_0000 | 32'($urandom_range(0, 16'hFFFF));
    #1;

    stalls = 0;
    while (cpu_stall === 1'b1 && stalls < 40) begin
      r = stalls;
      stalls++;
      ch_ack = '0;
      if (r >= 1) begin
        cmp({name, " ch_req"}, 128'(ch_req), 128'(exp_req));
        if (r == 1) begin
          cmp({name, " ch_we"},    128'(ch_we),    128'(wr));
          cmp({name, " ch_wdata"}, 128'(ch_wdata), 128'(wdata));
          cmp({name, " ch_addr"},  128'(ch_addr),  128'(addr % 16));
        end
        if (r == delay) begin
          ch_ack[idx] = 1'b1;
          ch_rdata[idx*DATA_W +: DATA_W] = rdata;
        end else if (noise) begin
          ch_ack[(idx + 1) % N_CH] = 1'b1;
        end
      end
      @(posedge cpu_clk); #1;
      ch_ack = '0;
    end

    if (ok && !wr) m_last_rd = rdata;
    exp_rd = ok ? m_last_rd : ERR_VAL;
    cmp({name, " stall_cycles"}, 128'(stalls), 128'(exp_stalls));
    cmp({name, " r_wdata"},      128'(r_wdata), 128'(exp_rd));
    cmp({name, " ch_req_end"},   128'(ch_req),  128'(0));

    if (!ok) begin
      m_bus_err  = 1'b1;
      m_err_addr = addr;
    end else if (clr_in_err) begin
      m_bus_err = 1'b0;
    end
    io_read = 0; io_write = 0; m_read = 0;
    err_clr = clr_in_err;
    @(posedge cpu_clk); #1;
    err_clr = 0;
    cmp({name, " bus_err"},  128'(bus_err),  128'(m_bus_err));
    cmp({name, " err_addr"}, 128'(err_addr), 128'(m_err_addr));
    cmp({name, " idle_stall"}, 128'(cpu_stall), 128'(0));
  endtask

  task automatic test_reset();
    idle_inputs();
    addr_in = '0; r_rdata = '0; m_rdata = '0; ch_rdata = '0;
    reset = 0;
    #12;
    cmp("reset ch_req",    128'(ch_req),    128'(0));
    cmp("reset ch_we",     128'(ch_we),     128'(0));
    cmp("reset ch_addr",   128'(ch_addr),   128'(0));
    cmp("reset ch_wdata",  128'(ch_wdata),  128'(0));
    cmp("reset cpu_stall", 128'(cpu_stall), 128'(0));
    cmp("reset bus_err",   128'(bus_err),   128'(0));
    cmp("reset err_addr",  128'(err_addr),  128'(0));
    reset = 1;
    @(posedge cpu_clk); #1;
  endtask

  task automatic test_mem_path();
    m_read = 1; addr_in = 32'h0000_0040; m_rdata = 32'h1234_5678; r_rdata = 32'hCAFE_0001;
    #1;
    cmp("mem r_wdata",    128'(r_wdata),    128'(32'h1234_5678));
    cmp("mem cpu_stall",  128'(cpu_stall),  128'(0));
    cmp("mem ch_req",     128'(ch_req),     128'(0));
    cmp("mem addr_out",   128'(addr_out),   128'(32'h0000_0040));
    cmp("mem write_data", 128'(write_data), 128'(32'hCAFE_0001));
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, d, w;
      a = $urandom & 32'h7FFF_FFFC; d = $urandom; w = $urandom;
      m_read = 0; m_write = 1; addr_in = a; r_rdata = w; m_rdata = d;
      #1;
      cmp("mem wr write_data", 128'(write_data), 128'(w));
      cmp("mem wr stall",      128'(cpu_stall),  128'(0));
      m_write = 0; m_read = 1;
      #1;
      cmp("mem rd r_wdata",  128'(r_wdata),  128'(d));
      cmp("mem rd addr_out", 128'(addr_out), 128'(a));
    end
    m_read = 0;
    @(posedge cpu_clk); #1;
  endtask

  task automatic test_io_write_fast();
    do_io("wr_ch1", 1'b1, 32'hFFFF_FC10, 32'h0000_00A5, 32'h0, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_io_read_wait();
    do_io("rd_ch2", 1'b0, 32'hFFFF_FC20, 32'h0, 32'h0000_0055, 4, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    do_io("timeout_ch3", 1'b0, 32'hFFFF_FC30, 32'h0, 32'h0, 100, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_err_clr();
    err_clr = 1;
    @(posedge cpu_clk); #1;
    err_clr = 0;
    m_bus_err = 1'b0;
    cmp("err_clr bus_err",  128'(bus_err),  128'(0));
    cmp("err_clr err_addr", 128'(err_addr), 128'(m_err_addr));
  endtask

  task automatic test_out_of_range();
    do_io("oor", 1'b0, 32'hFFFF_FD00, 32'h0, 32'h0, 1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_timeout_boundary();
    test_err_clr();
    do_io("ack_at_limit", 1'b0, 32'hFFFF_FC04, 32'h0, 32'h0BAD_F00D, TIMEOUT, 1'b0, 1'b0, 1'b0);
    do_io("ack_past_limit", 1'b0, 32'hFFFF_FC14, 32'h0, 32'h1111_2222, TIMEOUT + 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mem_io_overlap();
    do_io("mem_io_overlap", 1'b0, 32'hFFFF_FC28, 32'h0, 32'h7777_8888, 2, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      int idx, dly;
      logic [31:0] a;
      idx = ($urandom_range(0, 5) == 0) ? $urandom_range(N_CH, 63) : $urandom_range(0, N_CH - 1);
      a   = IO_BASE + 32'(idx * 16) + 32'($urandom_range(0, 15));
      dly = $urandom_range(1, TIMEOUT + 3);
      do_io("random", 1'($urandom_range(0, 1)), a, $urandom, $urandom, dly,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    io_read = 1; addr_in = 32'hFFFF_FC20; r_rdata = '0;
    @(posedge cpu_clk); #1;
    @(posedge cpu_clk); #1;
    cmp("midrst ch_req_before", 128'(ch_req), 128'(4'b0100));
    reset = 0;
    #1;
    cmp("midrst ch_req",    128'(ch_req),    128'(0));
    cmp("midrst cpu_stall", 128'(cpu_stall), 128'(0));
    cmp("midrst bus_err",   128'(bus_err),   128'(0));
    cmp("midrst err_addr",  128'(err_addr),  128'(0));
    io_read = 0;
    m_bus_err = 1'b0; m_err_addr = '0; m_last_rd = '0;
    #2;
    reset = 1;
    @(posedge cpu_clk); #1;
    do_io("after_reset_wr", 1'b1, 32'hFFFF_FC08, 32'h0BEE_F00D, 32'h0, 2, 1'b0, 1'b0, 1'b0);
    do_io("after_reset_rd", 1'b0, 32'hFFFF_FC3C, 32'h0, 32'h2468_ACE0, 3, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mem_path();
    test_io_write_fast();
    test_io_read_wait();
    test_timeout();
    test_err_clr();
    test_out_of_range();
    test_timeout_boundary();
    test_mem_io_overlap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
